// File: rtl/serial_deserializer.sv
// ============================================================================
// Module   : serial_deserializer
// Purpose  : MSB-first serial-in / parallel-out receiver. Completed words are
//            held on a valid/ready output while the next word shifts in. A
//            completed word that finds the output still occupied is dropped
//            and sets a sticky overflow flag.
// Options  : define SERIAL_DESERIALIZER_PARITY_EN to add a trailing
//            even-parity bit per word and report the result on parity_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sin,
  input  logic                         sin_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overflow,
  output logic                         parity_err
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH-1);
  localparam logic [0:0] S_COLLECT = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam logic [0:0] S_PARITY  = 1'b1;
  localparam int SR_W = WIDTH;
`else
  // The last data bit is taken straight from sin, so only WIDTH-1 bits are stored.
  localparam int SR_W = WIDTH - 1;
`endif

  logic [0:0]       state_q, state_d;
  logic [SR_W-1:0]  shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             perr_d;
  logic             complete;
  logic [WIDTH-1:0] word;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_COLLECT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_COLLECT;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    end else if (sin_valid) begin
      if (state_q == S_COLLECT && count_q == C_LAST) state_d = S_PARITY;
      else if (state_q == S_PARITY)                  state_d = S_COLLECT;
`endif
    end
  end

  // Output decode: word completion and the word it delivers
  always_comb begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    complete = !flush && sin_valid && (state_q == S_PARITY);
    word     = shift_q;
    perr_d   = (^shift_q) ^ sin;
`else
    complete = !flush && sin_valid && (state_q == S_COLLECT) && (count_q == C_LAST);
    word     = {shift_q, sin};
    perr_d   = 1'b0;
`endif
  end

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (flush) begin
      shift_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (sin_valid) begin
      if (state_q == S_COLLECT) shift_d = SR_W'({shift_q, sin});
      count_d = complete ? '0 : count_q + CW'(1);
    end
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  perr_q <= 1'b0;
    else if (complete && (!valid_q || dout_ready)) perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_d;
  assign parity_err  = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_count  = count_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// ============================================================================
// Module   : tb_serial_deserializer
// Purpose  : Directed self-checking bench for serial_deserializer (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [4:0]  bit_count;
  logic        overflow;
  logic        parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  serial_deserializer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_count  (bit_count),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends 16 data bits MSB first (plus a parity bit when enabled); ready is
  // raised only on the edge that completes the word.
  task automatic send_raw(input logic [15:0] w, input logic pbit, input logic rdy_last);
    for (int i = 15; i >= 0; i--) begin
      sin       = w[i];
      sin_valid = 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      dout_ready = 1'b0;
`else
      dout_ready = (i == 0) ? rdy_last : 1'b0;
`endif
      tick();
    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    sin        = pbit;
    dout_ready = rdy_last;
    tick();
`else
    if (pbit) sin = 1'b0;
`endif
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy_last);
    send_raw(w, ^w, rdy_last);
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'hAB;

    // Reset state
    #1 rst = 1'b0;
    #11;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    check("reset_count", 32'(bit_count), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
    check("reset_perr", 32'(parity_err), 32'h0);
    rst = 1'b1;

    // Basic word
    send_word(16'h1234, 1'b0);
    check("w1234_dout", 32'(dout), 32'h1234);
    check("w1234_valid", 32'(dout_valid), 32'h1);
    check("w1234_count", 32'(bit_count), 32'h0);
    check("w1234_ovf", 32'(overflow), 32'h0);
    consume();
    check("hs_valid", 32'(dout_valid), 32'h0);
    check("hs_dout_hold", 32'(dout), 32'h1234);

    // Backpressure and overflow
    send_word(16'hA5A5, 1'b0);
    check("a5_dout", 32'(dout), 32'hA5A5);
    send_word(16'h0F0F, 1'b0);
    check("ovf_dout_kept", 32'(dout), 32'hA5A5);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_valid", 32'(dout_valid), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ovf", 32'(overflow), 32'h0);
    check("flush_valid", 32'(dout_valid), 32'h1);
    check("flush_dout", 32'(dout), 32'hA5A5);
    consume();
    check("a5_consumed", 32'(dout_valid), 32'h0);

    // Back-to-back with ready on the completion edge
    send_word(16'h0001, 1'b0);
    check("w0001_dout", 32'(dout), 32'h0001);
    send_word(16'hFFFF, 1'b1);
    check("b2b_dout", 32'(dout), 32'hFFFF);
    check("b2b_valid", 32'(dout_valid), 32'h1);
    check("b2b_ovf", 32'(overflow), 32'h0);
    consume();

    // Gapped partial word, then mid-word reset
    for (int i = 7; i >= 0; i--) begin
      sin       = partial[i];
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      sin       = ~sin;
      tick();
    end
    check("gap_count", 32'(bit_count), 32'h8);
    check("gap_valid", 32'(dout_valid), 32'h0);
    rst = 1'b0;
    #3;
    check("midrst_count", 32'(bit_count), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    rst = 1'b1;
    send_word(16'hBEEF, 1'b0);
    check("beef_dout", 32'(dout), 32'hBEEF);
    check("beef_count", 32'(bit_count), 32'h0);
    consume();

    // Flush mid-word discards the partial word and the bit on sin that edge
    for (int i = 0; i < 5; i++) begin
      sin = 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sin_valid = 1'b0;
    check("flush_count", 32'(bit_count), 32'h0);
    send_word(16'h1234, 1'b0);
    check("after_flush_dout", 32'(dout), 32'h1234);
    check("perr_good", 32'(parity_err), 32'h0);
    consume();

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_raw(16'h1234, 1'b0, 1'b0);
    check("perr_bad", 32'(parity_err), 32'h1);
    check("perr_bad_dout", 32'(dout), 32'h1234);
    consume();
    send_raw(16'h1234, 1'b1, 1'b0);
    check("perr_ok", 32'(parity_err), 32'h0);
`else
    send_raw(16'h1235, 1'b0, 1'b0);
    check("perr_off", 32'(parity_err), 32'h0);
    check("w1235_dout", 32'(dout), 32'h1235);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in/parallel-out receiver; the far end of the team's 16-bit loadable shift register used as a serializer.
- Collects a bit stream presented on sin/sin_valid, MSB first, and assembles WIDTH-bit words.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Holds one completed word while the next word shifts in, with sticky overflow detection.

Parameters:
- WIDTH, 16, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; rst=0 clears all state immediately.
- sin  input  1  serial data bit.
- sin_valid  input  1  qualifies sin; one bit is consumed per rising edge with sin_valid=1.
- flush  input  1  synchronous clear of the partial word and the overflow flag.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1.
- bit_count  output  $clog2(WIDTH+1)  number of data bits held in the partial word.
- overflow  output  1  sticky; a completed word was dropped.
- parity_err  output  1  parity result for dout; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - shift_reg, dout, bit_count = 0.
  - dout_valid, overflow, parity_err = 0.
  - State = COLLECT.
- States:
  - COLLECT: receiving data bits.
  - PARITY: awaiting the parity bit; exists only with the macro.
- Shift rule in COLLECT, per edge with sin_valid=1:
  - shift_reg <= {shift_reg[WIDTH-2:0], sin}; the first bit received lands in dout[WIDTH-1].
  - bit_count <= bit_count+1.
- Word completion (macro off), on the edge where bit_count==WIDTH-1 and sin_valid=1:
  - completed word = {shift_reg[WIDTH-2:0], sin}.
  - bit_count <= 0; state stays COLLECT.
- Output register update, on a completion edge:
  - dout_valid=0, or dout_valid=1 with dout_ready=1: dout <= completed word; dout_valid <= 1.
  - dout_valid=1 with dout_ready=0: word dropped; dout is unchanged; overflow <= 1.
- Latency: dout/dout_valid change on the same edge that samples the last bit, and are visible 0 cycles after that edge. No combinational path from sin to dout.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion on that edge -> dout_valid <= 0; dout holds its value.
  - dout_ready is ignored while dout_valid=0.
  - dout_valid never drops without a handshake, flush excepted as stated below.
- sin_valid=0: no shift and no count change; gaps of any length are legal, including mid-word.
- flush=1, highest priority over sin_valid on the same edge:
  - bit_count <= 0; shift_reg <= 0; overflow <= 0; state <= COLLECT.
  - The bit on sin that edge is discarded.
  - dout and dout_valid are untouched; a pending handshake on that edge still completes.
- overflow clears only on reset or flush.
- Reset mid-word: the partial word is lost; the next bit after rst returns high is bit WIDTH-1 of a new word.

Optional Feature:
- Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined:
  - After WIDTH data bits the state moves to PARITY, with bit_count = WIDTH.
  - The next sin_valid bit is the even-parity bit, and it completes the word; bit_count <= 0; state <= COLLECT.
  - parity_err is loaded together with dout: parity_err = XOR of the WIDTH data bits and the parity bit; 1 = error.
  - Completion and overflow rules are as above, applied at the parity bit.
  - flush in PARITY returns to COLLECT.
- Undefined: no PARITY state; parity_err is tied 0.

Test Plan:
- Reset then shift: rst low 12 ns, then 16 bits of 0x1234 MSB first with sin_valid=1 -> dout=0x1234, dout_valid=1 after the 16th edge, bit_count back to 0.
- Backpressure and overflow: dout_ready=0; send 0xA5A5 then 0x0F0F -> dout=0xA5A5, overflow=1 after word 2; then flush=1 for 1 cycle -> overflow=0, dout_valid still 1.
- Back-to-back with ready: dout_ready held 1 on the completion edge of word 2 (0xFFFF after 0x0001) -> dout=0xFFFF, overflow=0, dout_valid stays 1.
- Gaps and mid-word reset: 8 bits of 0xAB with sin_valid toggling, rst pulsed low, then 16 bits 0xBEEF -> dout=0xBEEF, bit_count=8 before the reset and 0 after.
- Parity (macro on): 0x1234 + parity bit 1 -> parity_err=0; 0x1234 + parity bit 0 -> parity_err=1; macro off -> parity_err=0 always.
